// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: request strobe, operands and opcode in;
// one-cycle result pulse with result, zero flag and divide-by-zero indication out.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic [WIDTH-1:0] Y;
   logic             flag;
   logic             err;

   modport master (
      output in_valid, a, b, op,
      input  in_ready, out_valid, Y, flag, err
   );

   modport slave (
      input  in_valid, a, b, op,
      output in_ready, out_valid, Y, flag, err
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: logic/arith/shift ops in 1 cycle, MUL/DIV/REM iterate one bit per cycle (WIDTH+1).
// Accepts one request at a time (in_ready low while busy); no output back-pressure, results held until replaced.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int MD_EN = 1
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} md_t;

   state_t           r_state;
   md_t              r_md;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_y_out;
   logic             r_flag;
   logic             r_err;
   logic             r_out_valid;
   logic             r_in_ready;

   logic             w_accept;
   logic             w_is_md;
   logic             w_div0;
   logic [WIDTH-1:0] w_y_imm;
   logic             w_err_imm;
   logic [WIDTH:0]   w_sh;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_acc_nx;
   logic [WIDTH-1:0] w_x_nx;
   logic [WIDTH-1:0] w_y_nx;
   logic [WIDTH-1:0] w_res;

   assign w_accept = bus.in_valid && r_in_ready;
   assign w_is_md  = (MD_EN != 0) && ((bus.op == 4'd8) || (bus.op == 4'd9) || (bus.op == 4'd10));
   assign w_div0   = w_is_md && (bus.op != 4'd8) && (bus.b == '0);

   always_comb begin
      w_y_imm   = '0;
      w_err_imm = 1'b0;
      case (bus.op)
         4'd0:    w_y_imm = bus.a & bus.b;
         4'd1:    w_y_imm = bus.a | bus.b;
         4'd2:    w_y_imm = bus.a + bus.b;
         4'd3:    w_y_imm = bus.a - bus.b;
         4'd4:    w_y_imm = bus.a ^ bus.b;
         4'd5:    w_y_imm = bus.a << bus.b[SHW-1:0];
         4'd6:    w_y_imm = bus.a >> bus.b[SHW-1:0];
         4'd7:    w_y_imm = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         4'd9: begin
            if (w_div0) begin
               w_y_imm   = '1;
               w_err_imm = 1'b1;
            end
         end
         4'd10: begin
            if (w_div0) begin
               w_y_imm   = bus.a;
               w_err_imm = 1'b1;
            end
         end
         default: w_y_imm = '0;
      endcase
   end

   // MUL: r_x = shifted multiplicand, r_y = shifted multiplier, r_acc = product.
   // DIV/REM: r_x = dividend shifting out / quotient shifting in, r_y = divisor, r_acc = partial remainder.
   always_comb begin
      w_sh     = {r_acc, r_x[WIDTH-1]};
      w_diff   = w_sh - {1'b0, r_y};
      w_ge     = ~w_diff[WIDTH];
      w_acc_nx = r_acc;
      w_x_nx   = r_x;
      w_y_nx   = r_y;
      w_res    = '0;
      if (r_md == MD_MUL) begin
         w_acc_nx = r_acc + (r_y[0] ? r_x : '0);
         w_x_nx   = r_x << 1;
         w_y_nx   = r_y >> 1;
         w_res    = w_acc_nx;
      end else begin
         w_acc_nx = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
         w_x_nx   = {r_x[WIDTH-2:0], w_ge};
         w_res    = (r_md == MD_DIV) ? w_x_nx : w_acc_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_md        <= MD_MUL;
         r_cnt       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_acc       <= '0;
         r_y_out     <= '0;
         r_flag      <= 1'b1;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  if (w_is_md && !w_div0) begin
                     r_x     <= bus.a;
                     r_y     <= bus.b;
                     r_acc   <= '0;
                     r_cnt   <= CW'(WIDTH);
                     r_md    <= (bus.op == 4'd8) ? MD_MUL : ((bus.op == 4'd9) ? MD_DIV : MD_REM);
                     r_state <= ITER;
                  end else begin
                     r_y_out     <= w_y_imm;
                     r_flag      <= (w_y_imm == '0);
                     r_err       <= w_err_imm;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            ITER: begin
               r_acc <= w_acc_nx;
               r_x   <= w_x_nx;
               r_y   <= w_y_nx;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_y_out     <= w_res;
                  r_flag      <= (w_res == '0);
                  r_err       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.Y         = r_y_out;
   assign bus.flag      = r_flag;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: issued requests push model results, a negedge monitor pops and compares.
module tb_alu_seq;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   alu_seq_if #(.WIDTH(W)) bus ();
   alu_seq #(.WIDTH(W), .MD_EN(1)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] y;
      logic         flag;
      logic         err;
      int           lat;
      int           acc;
   } exp_t;

   exp_t         sb_q[$];
   exp_t         mon_e;
   int           checks   = 0;
   int           failures = 0;
   int           cyc      = 0;
   logic [W-1:0] last_y   = '0;
   logic         last_flag = 1'b1;
   logic         last_err  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference results from plain arithmetic on the opcode definitions.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t   e;
      longint ua = longint'(x);
      longint ub = longint'(y);
      e.err = 1'b0;
      e.lat = 1;
      e.acc = 0;
      case (o)
         4'd0:  e.y = x & y;
         4'd1:  e.y = x | y;
         4'd2:  e.y = W'(ua + ub);
         4'd3:  e.y = W'(ua - ub);
         4'd4:  e.y = x ^ y;
         4'd5:  e.y = W'(ua << (ub % W));
         4'd6:  e.y = W'(ua >> (ub % W));
         4'd7:  e.y = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
         4'd8: begin
            e.y   = W'(ua * ub);
            e.lat = W + 1;
         end
         4'd9: begin
            if (ub == 0) begin
               e.y   = '1;
               e.err = 1'b1;
            end else begin
               e.y   = W'(ua / ub);
               e.lat = W + 1;
            end
         end
         4'd10: begin
            if (ub == 0) begin
               e.y   = x;
               e.err = 1'b1;
            end else begin
               e.y   = W'(ua % ub);
               e.lat = W + 1;
            end
         end
         default: e.y = '0;
      endcase
      e.flag = (e.y == '0);
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         last_y    = '0;
         last_flag = 1'b1;
         last_err  = 1'b0;
      end else if (bus.out_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_out_valid: got out_valid=1 Y=%0h expected no pending result (cycle %0d)", bus.Y, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("Y", bus.Y, mon_e.y);
            chk("flag", bus.flag, mon_e.flag);
            chk("err", bus.err, mon_e.err);
            chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
            last_y    = mon_e.y;
            last_flag = mon_e.flag;
            last_err  = mon_e.err;
         end
      end else begin
         chk("hold_Y", bus.Y, last_y);
         chk("hold_flag", bus.flag, last_flag);
         chk("hold_err", bus.err, last_err);
      end
   end

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit keep, output int acc);
      exp_t e;
      int   n = 0;
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.a        = x;
      bus.b        = y;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", n);
         bus.in_valid = 1'b0;
         acc = -1;
         return;
      end
      e     = model(o, x, y);
      e.acc = cyc + 1;
      acc   = e.acc;
      sb_q.push_back(e);
      @(negedge clk);
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a1, a2, a3, acc;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.op       = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_Y", bus.Y, 0);
      chk("rst_flag", bus.flag, 1);
      chk("rst_err", bus.err, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("in_ready_after_release", bus.in_ready, 1);
      @(negedge clk);

      issue(4'd2, 16'd15, 16'd11, 0, acc);
      drain();
      issue(4'd5, 16'd15, 16'd11, 0, acc);
      issue(4'd6, 16'd15, 16'd11, 0, acc);
      issue(4'd7, 16'hFFFF, 16'd1, 0, acc);
      drain();

      issue(4'd3, 16'd11, 16'd11, 1, a1);
      issue(4'd4, 16'h1234, 16'h00FF, 1, a2);
      issue(4'd0, 16'hF0F0, 16'h0FF0, 0, a3);
      chk("b2b_spacing_1", a2 - a1, 2);
      chk("b2b_spacing_2", a3 - a2, 2);
      drain();

      issue(4'd8, 16'd300, 16'd300, 0, acc);
      for (int i = 0; i < 15; i++) begin
         chk("in_ready_iter", bus.in_ready, 0);
         bus.in_valid = (i % 2 == 0);
         bus.a        = W'($urandom);
         bus.b        = W'($urandom);
         bus.op       = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      drain();

      issue(4'd9, 16'd100, 16'd7, 0, acc);
      issue(4'd10, 16'd100, 16'd7, 0, acc);
      issue(4'd9, 16'd5, 16'd0, 0, acc);
      issue(4'd10, 16'd5, 16'd0, 0, acc);
      issue(4'd15, 16'd5, 16'd9, 0, acc);
      drain();

      issue(4'd8, 16'd1234, 16'd567, 0, acc);
      repeat (4) @(negedge clk);
      sb_q.delete();
      #2 rst = 1'b0;
      #1;
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_Y", bus.Y, 0);
      chk("abort_flag", bus.flag, 1);
      chk("abort_err", bus.err, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_in_ready_release", bus.in_ready, 1);
      @(negedge clk);
      issue(4'd2, 16'd40, 16'd2, 0, acc);
      drain();

      for (int k = 0; k < 400; k++) begin
         logic [3:0]   o;
         logic [W-1:0] x, y;
         int           gap;
         o   = 4'($urandom_range(0, 15));
         x   = W'($urandom);
         y   = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
         gap = $urandom_range(0, 2);
         issue(o, x, y, 1, acc);
         if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
      end
      bus.in_valid = 1'b0;
      drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (legal 4..32).
REQ-002 Parameter MD_EN, default 1, 1 = multiply/divide ops implemented; 0 = those opcodes treated as undefined.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; one clock domain only.
REQ-005 in_valid  input  1  request strobe; a, b, op sampled when in_valid and in_ready both high.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A, unsigned unless op states otherwise.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  4  opcode.
REQ-010 out_valid  output  1  one-cycle pulse, Y/flag/err valid in that cycle only.
REQ-011 Y  output  WIDTH  result, registered.
REQ-012 flag  output  1  zero flag, high when Y == 0, registered with Y.
REQ-013 err  output  1  divide-by-zero indication, registered with Y.

Function
REQ-014 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB (a-b), 0100 XOR, 0101 SLL (a << b[log2 WIDTH-1:0]), 0110 SRL (logical), 0111 SLT (signed, Y=1/0), 1000 MUL (low WIDTH bits of a*b), 1001 DIV (unsigned quotient), 1010 REM (unsigned remainder), all others undefined.
REQ-015 ADD/SUB/MUL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-016 Undefined opcode: Y=0, flag=1, err=0, single-cycle latency.
REQ-017 FSM states IDLE, ITER, DONE; reset state IDLE.
REQ-018 IDLE: in_ready=1; on accept of single-cycle op (0000-0111, undefined, or div-by-zero) result registered and state -> DONE.
REQ-019 IDLE: on accept of MUL/DIV/REM with b != 0 (MD_EN=1), load operands, iteration counter = WIDTH, state -> ITER.
REQ-020 ITER: in_ready=0; one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle; counter decrements; at counter 1 -> DONE with result loaded.
REQ-021 DONE: out_valid=1 for exactly one cycle, in_ready=0, then -> IDLE.
REQ-022 Latency accept-edge to out_valid: single-cycle ops 1 cycle; MUL/DIV/REM WIDTH+1 cycles.
REQ-023 Y, flag, err hold last result after out_valid falls until next result loads.
REQ-024 Divide-by-zero (DIV or REM, b == 0): DIV Y = all ones, REM Y = a, err=1, single-cycle latency; err=0 for every other result.
REQ-025 in_valid while in_ready=0 is ignored; requester holds it; no queuing, no back-pressure on output.
REQ-026 Operand inputs changing during ITER do not affect the in-flight result.

Reset
REQ-027 rst low asynchronously forces: state IDLE, out_valid=0, Y=0, flag=1, err=0, counter=0, operand registers 0.
REQ-028 in_ready=1 while rst low and in first cycle after release.
REQ-029 Reset during ITER aborts the operation; no out_valid is produced for it.

Verification
REQ-030 WIDTH=16, ADD a=15 b=11 -> out_valid 1 cycle after accept, Y=26, flag=0, err=0.
REQ-031 SLL a=15 b=11 -> Y=0x7800; SRL a=15 b=11 -> Y=0; SLT a=0xFFFF b=1 -> Y=1.
REQ-032 SUB a=11 b=11 -> Y=0, flag=1; back-to-back requests accepted every 2 cycles.
REQ-033 MUL a=300 b=300 -> Y=0x5F90, out_valid 17 cycles after accept, in_ready low for 16 cycles between; in_valid pulses during ITER ignored.
REQ-034 DIV a=100 b=7 -> Y=14; REM a=100 b=7 -> Y=2; DIV a=5 b=0 -> Y=0xFFFF, err=1, latency 1.
REQ-035 rst asserted 5 cycles into MUL -> outputs at reset values immediately, no out_valid, next ADD after release completes normally.
